// File: rtl/excp_ctrl.sv
// Exception/interrupt sequencer: prioritises a committing event, pulses the CP0 update, holds flush, then redirects fetch.
// Optional event counters (exc_count, int_count) are built when EXCP_CTRL_STATS_EN is defined.
module excp_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic [7:0]  exc_vec,
    input  logic [31:0] commit_pc,
    input  logic        commit_in_ds,
    input  logic [31:0] mem_addr,
    input  logic        int_pending,
    input  logic        status_ie,
    input  logic        status_exl,
    input  logic [31:0] cp0_epc_i,
    output logic        cp0_exc_we,
    output logic        cp0_epc_we,
    output logic [4:0]  cp0_exc_code,
    output logic [31:0] cp0_epc_o,
    output logic        cp0_bd_o,
    output logic        cp0_badv_we,
    output logic [31:0] cp0_badv_o,
    output logic        cp0_eret,
    output logic        flush_o,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready
`ifdef EXCP_CTRL_STATS_EN
    ,
    output logic [31:0] exc_count,
    output logic [15:0] int_count
`endif
);

    typedef enum logic [1:0] {IDLE, CP0WR, FLUSH, REDIR} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        ev_eret;
    logic        int_take;
    logic        take;
    logic [4:0]  code_sel;
    logic        badv_we_sel;
    logic [31:0] badv_sel;
    logic        eret_sel;

    // Event selection, highest priority first
    always_comb begin
        int_take    = int_pending & status_ie & ~status_exl;
        take        = (state == IDLE) & commit_valid & (int_take | (|exc_vec));
        code_sel    = 5'd0;
        badv_we_sel = 1'b0;
        badv_sel    = 32'd0;
        eret_sel    = 1'b0;
        if (int_take) begin
            code_sel = 5'd0;
        end else if (exc_vec[7]) begin
            code_sel    = 5'd4;
            badv_we_sel = 1'b1;
            badv_sel    = commit_pc;
        end else if (exc_vec[6]) begin
            code_sel = 5'd10;
        end else if (exc_vec[5]) begin
            code_sel = 5'd12;
        end else if (exc_vec[4]) begin
            code_sel = 5'd9;
        end else if (exc_vec[3]) begin
            code_sel = 5'd8;
        end else if (exc_vec[2]) begin
            code_sel    = 5'd4;
            badv_we_sel = 1'b1;
            badv_sel    = mem_addr;
        end else if (exc_vec[1]) begin
            code_sel    = 5'd5;
            badv_we_sel = 1'b1;
            badv_sel    = mem_addr;
        end else if (exc_vec[0]) begin
            eret_sel = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (take) begin
                    state_nxt = CP0WR;
                    cnt_nxt   = 4'(FLUSH_CYCLES - 1);
                end
            end
            CP0WR: begin
                state_nxt = (cnt == 4'd0) ? REDIR : FLUSH;
            end
            FLUSH: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) state_nxt = REDIR;
            end
            REDIR: begin
                if (redir_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered outputs; data fields are latched at the take cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            commit_ready <= 1'b1;
            flush_o      <= 1'b0;
            redir_valid  <= 1'b0;
            redir_pc     <= 32'd0;
            cp0_exc_we   <= 1'b0;
            cp0_eret     <= 1'b0;
            cp0_epc_we   <= 1'b0;
            cp0_badv_we  <= 1'b0;
            cp0_exc_code <= 5'd0;
            cp0_epc_o    <= 32'd0;
            cp0_bd_o     <= 1'b0;
            cp0_badv_o   <= 32'd0;
            ev_eret      <= 1'b0;
        end else begin
            commit_ready <= (state_nxt == IDLE);
            flush_o      <= (state_nxt == CP0WR) || (state_nxt == FLUSH);
            redir_valid  <= (state_nxt == REDIR);
            cp0_exc_we   <= take & ~eret_sel;
            cp0_eret     <= take & eret_sel;
            cp0_epc_we   <= take & ~eret_sel & ~status_exl;
            cp0_badv_we  <= take & badv_we_sel;
            if (take) begin
                cp0_exc_code <= code_sel;
                cp0_epc_o    <= commit_in_ds ? (commit_pc - 32'd4) : commit_pc;
                cp0_bd_o     <= commit_in_ds;
                cp0_badv_o   <= badv_sel;
                ev_eret      <= eret_sel & ~int_take;
            end
            // ERET target is captured once, as the redirect is raised
            if (state != REDIR && state_nxt == REDIR)
                redir_pc <= ev_eret ? cp0_epc_i : EXC_VECTOR;
        end
    end

`ifdef EXCP_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            exc_count <= 32'd0;
            int_count <= 16'd0;
        end else begin
            if (take && !eret_sel && exc_count != 32'hFFFF_FFFF)
                exc_count <= exc_count + 32'd1;
            if (take && int_take && int_count != 16'hFFFF)
                int_count <= int_count + 16'd1;
        end
    end
`endif

endmodule
